// File: rtl/ppg_pkg.sv
// Shared encodings and default widths for the PPG channel demultiplexer.
// The LED phase code is {led_ir, led_red}.
package ppg_pkg;

    localparam int ADC_W  = 8;
    localparam int DC_W   = 7;
    localparam int GAIN_W = 4;

    localparam logic [1:0] PH_NONE = 2'b00;
    localparam logic [1:0] PH_RED  = 2'b01;
    localparam logic [1:0] PH_IR   = 2'b10;
    localparam logic [1:0] PH_BOTH = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        ACC   = 2'd2
    } state_e;

    function automatic logic phase_is_valid(input logic [1:0] ph);
        logic ok;
        case (ph)
            PH_IR:   ok = 1'b1;
            PH_RED:  ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ppg_window_acc.sv
// Box-car window accumulator shared by both channels. done_o/mean_o/sat_o are
// combinational and describe the window closed by the current sample.
module ppg_window_acc #(
    parameter int ADC_W    = 8,
    parameter int AVG_LOG2 = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [ADC_W-1:0]    sample_i,
    output logic [AVG_LOG2-1:0] n_o,
    output logic                done_o,
    output logic [ADC_W-1:0]    mean_o,
    output logic                sat_o
);

    localparam int SUM_W = ADC_W + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] N_LAST = {AVG_LOG2{1'b1}};
    localparam logic [AVG_LOG2-1:0] N_ONE  = AVG_LOG2'(1);

    logic [SUM_W-1:0]    sum_q;
    logic [AVG_LOG2-1:0] n_q;
    logic                flag_q;
    logic [SUM_W-1:0]    sum_ext_s;
    logic                rail_s;
    logic                last_s;

    // A sample sitting on either ADC rail means the window may be clipped.
    function automatic logic is_rail(input logic [ADC_W-1:0] v);
        return (v == {ADC_W{1'b0}}) || (v == {ADC_W{1'b1}});
    endfunction

    // Window arithmetic including the sample presented this cycle.
    always_comb begin
        sum_ext_s = sum_q + {{AVG_LOG2{1'b0}}, sample_i};
        rail_s    = is_rail(sample_i);
        last_s    = en_i && (n_q == N_LAST);
    end

    assign n_o    = n_q;
    assign done_o = last_s;
    assign mean_o = sum_ext_s[SUM_W-1:AVG_LOG2];
    assign sat_o  = flag_q | rail_s;

    // Sum, sample count and saturation flag; a finished window clears itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= {SUM_W{1'b0}};
            n_q    <= {AVG_LOG2{1'b0}};
            flag_q <= 1'b0;
        end else if (clr_i || last_s) begin
            sum_q  <= {SUM_W{1'b0}};
            n_q    <= {AVG_LOG2{1'b0}};
            flag_q <= 1'b0;
        end else if (en_i) begin
            sum_q  <= sum_ext_s;
            n_q    <= n_q + N_ONE;
            flag_q <= flag_q | rail_s;
        end else begin
            sum_q  <= sum_q;
            n_q    <= n_q;
            flag_q <= flag_q;
        end
    end

endmodule

// File: rtl/ppg_channel_demux.sv
// Splits the interleaved IR/RED ADC stream, blanks analog settling after any
// LED or setting change, and emits tagged box-car averages per channel.
module ppg_channel_demux #(
    parameter int ADC_W        = ppg_pkg::ADC_W,
    parameter int DC_W         = ppg_pkg::DC_W,
    parameter int GAIN_W       = ppg_pkg::GAIN_W,
    parameter int BLANK_CYCLES = 4,
    parameter int AVG_LOG2     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADC_W-1:0]  adc_i,
    input  logic              led_ir_i,
    input  logic              led_red_i,
    input  logic [DC_W-1:0]   dc_comp_i,
    input  logic [GAIN_W-1:0] pga_gain_i,
    input  logic              calib_busy_i,
    output logic [ADC_W-1:0]  ir_data_o,
    output logic              ir_valid_o,
    output logic [DC_W-1:0]   ir_dc_tag_o,
    output logic [GAIN_W-1:0] ir_gain_tag_o,
    output logic              ir_sat_o,
    output logic [ADC_W-1:0]  red_data_o,
    output logic              red_valid_o,
    output logic [DC_W-1:0]   red_dc_tag_o,
    output logic [GAIN_W-1:0] red_gain_tag_o,
    output logic              red_sat_o,
    output logic              phase_err_o,
    output logic [7:0]        abort_cnt_o
);

    import ppg_pkg::*;

    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);
    localparam logic [BW-1:0] BLANK_ONE  = BW'(1);

    state_e            state_q, state_d;
    logic [1:0]        phase_q, phase_d;
    logic [DC_W-1:0]   dc_q, dc_d;
    logic [GAIN_W-1:0] gain_q, gain_d;
    logic [BW-1:0]     blank_q, blank_d;
    logic [7:0]        abort_q, abort_d;
    logic              both_prev_q;

    logic [ADC_W-1:0]  ir_data_q, red_data_q;
    logic              ir_valid_q, red_valid_q;
    logic [DC_W-1:0]   ir_dc_q, red_dc_q;
    logic [GAIN_W-1:0] ir_gain_q, red_gain_q;
    logic              ir_sat_q, red_sat_q;
    logic              phase_err_q;

    logic [1:0]          phase_s;
    logic                stop_s;
    logic                change_s;
    logic                both_s;
    logic                acc_clr_s;
    logic                acc_en_s;
    logic                abort_s;
    logic [AVG_LOG2-1:0] acc_n_s;
    logic                acc_done_s;
    logic [ADC_W-1:0]    acc_mean_s;
    logic                acc_sat_s;

    // Input classification; stop outranks a setting change.
    always_comb begin
        phase_s  = {led_ir_i, led_red_i};
        both_s   = (phase_s == PH_BOTH);
        stop_s   = calib_busy_i || !phase_is_valid(phase_s);
        change_s = (phase_s != phase_q) || (dc_comp_i != dc_q) || (pga_gain_i != gain_q);
    end

    // Next-state logic; the accumulator is held clear unless a sample is taken.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        dc_d      = dc_q;
        gain_d    = gain_q;
        blank_d   = blank_q;
        acc_clr_s = 1'b1;
        acc_en_s  = 1'b0;
        abort_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!stop_s) begin
                    phase_d = phase_s;
                    dc_d    = dc_comp_i;
                    gain_d  = pga_gain_i;
                    blank_d = {BW{1'b0}};
                    state_d = BLANK;
                end else begin
                    state_d = IDLE;
                end
            end
            BLANK: begin
                if (stop_s) begin
                    state_d = IDLE;
                end else if (change_s) begin
                    phase_d = phase_s;
                    dc_d    = dc_comp_i;
                    gain_d  = pga_gain_i;
                    blank_d = {BW{1'b0}};
                end else if (blank_q == BLANK_LAST) begin
                    blank_d = {BW{1'b0}};
                    state_d = ACC;
                end else begin
                    blank_d = blank_q + BLANK_ONE;
                end
            end
            ACC: begin
                if (stop_s) begin
                    state_d = IDLE;
                    abort_s = (acc_n_s != {AVG_LOG2{1'b0}});
                end else if (change_s) begin
                    phase_d = phase_s;
                    dc_d    = dc_comp_i;
                    gain_d  = pga_gain_i;
                    blank_d = {BW{1'b0}};
                    state_d = BLANK;
                    abort_s = (acc_n_s != {AVG_LOG2{1'b0}});
                end else begin
                    acc_clr_s = 1'b0;
                    acc_en_s  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Saturating count of windows thrown away part-way through.
    always_comb begin
        if (abort_s && (abort_q != 8'hFF)) begin
            abort_d = abort_q + 8'd1;
        end else begin
            abort_d = abort_q;
        end
    end

    ppg_window_acc #(
        .ADC_W    (ADC_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (acc_clr_s),
        .en_i     (acc_en_s),
        .sample_i (adc_i),
        .n_o      (acc_n_s),
        .done_o   (acc_done_s),
        .mean_o   (acc_mean_s),
        .sat_o    (acc_sat_s)
    );

    // Control state, latched settings and abort counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= PH_NONE;
            dc_q        <= {DC_W{1'b0}};
            gain_q      <= {GAIN_W{1'b0}};
            blank_q     <= {BW{1'b0}};
            abort_q     <= 8'd0;
            both_prev_q <= 1'b0;
            phase_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            dc_q        <= dc_d;
            gain_q      <= gain_d;
            blank_q     <= blank_d;
            abort_q     <= abort_d;
            both_prev_q <= both_s;
            phase_err_q <= both_s && !both_prev_q;
        end
    end

    // Steer a completed window to the latched channel; data and tags hold between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_valid_q  <= 1'b0;
            ir_data_q   <= {ADC_W{1'b0}};
            ir_dc_q     <= {DC_W{1'b0}};
            ir_gain_q   <= {GAIN_W{1'b0}};
            ir_sat_q    <= 1'b0;
            red_valid_q <= 1'b0;
            red_data_q  <= {ADC_W{1'b0}};
            red_dc_q    <= {DC_W{1'b0}};
            red_gain_q  <= {GAIN_W{1'b0}};
            red_sat_q   <= 1'b0;
        end else begin
            ir_valid_q  <= acc_done_s && (phase_q == PH_IR);
            red_valid_q <= acc_done_s && (phase_q == PH_RED);
            if (acc_done_s && (phase_q == PH_IR)) begin
                ir_data_q <= acc_mean_s;
                ir_dc_q   <= dc_q;
                ir_gain_q <= gain_q;
                ir_sat_q  <= acc_sat_s;
            end else begin
                ir_data_q <= ir_data_q;
                ir_dc_q   <= ir_dc_q;
                ir_gain_q <= ir_gain_q;
                ir_sat_q  <= ir_sat_q;
            end
            if (acc_done_s && (phase_q == PH_RED)) begin
                red_data_q <= acc_mean_s;
                red_dc_q   <= dc_q;
                red_gain_q <= gain_q;
                red_sat_q  <= acc_sat_s;
            end else begin
                red_data_q <= red_data_q;
                red_dc_q   <= red_dc_q;
                red_gain_q <= red_gain_q;
                red_sat_q  <= red_sat_q;
            end
        end
    end

    assign ir_data_o      = ir_data_q;
    assign ir_valid_o     = ir_valid_q;
    assign ir_dc_tag_o    = ir_dc_q;
    assign ir_gain_tag_o  = ir_gain_q;
    assign ir_sat_o       = ir_sat_q;
    assign red_data_o     = red_data_q;
    assign red_valid_o    = red_valid_q;
    assign red_dc_tag_o   = red_dc_q;
    assign red_gain_tag_o = red_gain_q;
    assign red_sat_o      = red_sat_q;
    assign phase_err_o    = phase_err_q;
    assign abort_cnt_o    = abort_q;

endmodule

// File: tb/tb_ppg_channel_demux.sv
// Directed bench for ppg_channel_demux with default parameters; expected
// values are hand-computed from the window/blanking timing.
module tb_ppg_channel_demux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] adc;
    logic       led_ir, led_red;
    logic [6:0] dc_comp;
    logic [3:0] pga_gain;
    logic       calib_busy;
    logic [7:0] ir_data, red_data;
    logic       ir_valid, red_valid, ir_sat, red_sat;
    logic [6:0] ir_dc_tag, red_dc_tag;
    logic [3:0] ir_gain_tag, red_gain_tag;
    logic       phase_err;
    logic [7:0] abort_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic si, sr;

    always #5 clk = ~clk;

    ppg_channel_demux dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .adc_i          (adc),
        .led_ir_i       (led_ir),
        .led_red_i      (led_red),
        .dc_comp_i      (dc_comp),
        .pga_gain_i     (pga_gain),
        .calib_busy_i   (calib_busy),
        .ir_data_o      (ir_data),
        .ir_valid_o     (ir_valid),
        .ir_dc_tag_o    (ir_dc_tag),
        .ir_gain_tag_o  (ir_gain_tag),
        .ir_sat_o       (ir_sat),
        .red_data_o     (red_data),
        .red_valid_o    (red_valid),
        .red_dc_tag_o   (red_dc_tag),
        .red_gain_tag_o (red_gain_tag),
        .red_sat_o      (red_sat),
        .phase_err_o    (phase_err),
        .abort_cnt_o    (abort_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, output logic saw_ir, output logic saw_red);
        saw_ir  = 1'b0;
        saw_red = 1'b0;
        repeat (n) begin
            step();
            saw_ir  = saw_ir | ir_valid;
            saw_red = saw_red | red_valid;
        end
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, " ir_data"},   {24'd0, ir_data}, 32'd0);
        check({pfx, " valids"},    {30'd0, ir_valid, red_valid}, 32'd0);
        check({pfx, " tags"},      {10'd0, ir_dc_tag, ir_gain_tag, red_dc_tag, red_gain_tag}, 32'd0);
        check({pfx, " sats/perr"}, {29'd0, ir_sat, red_sat, phase_err}, 32'd0);
        check({pfx, " red_data"},  {24'd0, red_data}, 32'd0);
        check({pfx, " abort_cnt"}, {24'd0, abort_cnt}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; adc = 8'd0; led_ir = 1'b0; led_red = 1'b0;
        dc_comp = 7'd0; pga_gain = 4'd0; calib_busy = 1'b0;
        repeat (3) step();
        check_all_zero("reset");

        // IR steady, constant 100: first strobe after E12, then every 8 cycles
        led_ir = 1'b1; dc_comp = 7'd64; pga_gain = 4'd7; adc = 8'd100;
        rst_n = 1'b1;
        run(12, si, sr);
        check("t1 no early strobe", {30'd0, si, sr}, 32'd0);
        step();
        check("t1 ir_valid", {31'd0, ir_valid}, 32'd1);
        check("t1 ir_data", {24'd0, ir_data}, 32'd100);
        check("t1 tags", {21'd0, ir_dc_tag, ir_gain_tag}, {21'd0, 7'd64, 4'd7});
        check("t1 sat/red_valid", {30'd0, ir_sat, red_valid}, 32'd0);
        run(7, si, sr);
        check("t1 gap quiet", {30'd0, si, sr}, 32'd0);
        step();
        check("t1 second strobe", {31'd0, ir_valid}, 32'd1);
        check("t1 second data", {24'd0, ir_data}, 32'd100);

        // Ramp 10..80: 360 >> 3 = 45
        for (int i = 0; i < 8; i++) begin
            adc = 8'((i + 1) * 10);
            step();
        end
        check("t2 ramp valid", {31'd0, ir_valid}, 32'd1);
        check("t2 ramp data", {24'd0, ir_data}, 32'd45);

        // Switch to RED after 5 accumulated samples
        adc = 8'd100;
        repeat (5) step();
        led_ir = 1'b0; led_red = 1'b1; adc = 8'd200;
        step();
        check("t3 abort_cnt", {24'd0, abort_cnt}, 32'd1);
        run(11, si, sr);
        check("t3 quiet after switch", {30'd0, si, sr}, 32'd0);
        step();
        check("t3 red_valid", {30'd0, ir_valid, red_valid}, 32'd1);
        check("t3 red_data", {24'd0, red_data}, 32'd200);
        check("t3 red tags", {21'd0, red_dc_tag, red_gain_tag}, {21'd0, 7'd64, 4'd7});
        check("t3 ir_data held", {24'd0, ir_data}, 32'd45);

        // dc_comp change mid-window re-blanks and retags
        repeat (3) step();
        dc_comp = 7'd65;
        step();
        check("t4 abort_cnt", {24'd0, abort_cnt}, 32'd2);
        run(11, si, sr);
        check("t4 quiet after change", {30'd0, si, sr}, 32'd0);
        step();
        check("t4 red_valid", {31'd0, red_valid}, 32'd1);
        check("t4 red_dc_tag", {25'd0, red_dc_tag}, 32'd65);
        check("t4 red_data", {24'd0, red_data}, 32'd200);

        // One rail sample: (7*200+255)>>3 = 206, sat for this window only
        for (int i = 0; i < 8; i++) begin
            adc = (i == 4) ? 8'd255 : 8'd200;
            step();
        end
        check("t5 sat valid", {31'd0, red_valid}, 32'd1);
        check("t5 sat data", {24'd0, red_data}, 32'd206);
        check("t5 red_sat set", {31'd0, red_sat}, 32'd1);
        adc = 8'd200;
        run(7, si, sr);
        step();
        check("t5 next valid", {31'd0, red_valid}, 32'd1);
        check("t5 red_sat clear", {31'd0, red_sat}, 32'd0);
        check("t5 next data", {24'd0, red_data}, 32'd200);

        // Both LEDs for 3 cycles, then calib_busy, then reset mid-window
        repeat (2) step();
        led_ir = 1'b1;
        step();
        check("t6 phase_err first", {31'd0, phase_err}, 32'd1);
        check("t6 abort_cnt", {24'd0, abort_cnt}, 32'd3);
        step();
        check("t6 phase_err once", {31'd0, phase_err}, 32'd0);
        step();
        check("t6 phase_err third", {31'd0, phase_err}, 32'd0);
        led_red = 1'b0; calib_busy = 1'b1;
        run(15, si, sr);
        check("t6 busy quiet", {30'd0, si, sr}, 32'd0);
        check("t6 busy no abort", {24'd0, abort_cnt}, 32'd3);
        calib_busy = 1'b0;
        repeat (8) step();
        rst_n = 1'b0;
        #2;
        check_all_zero("t6 async reset");
        step();
        led_ir = 1'b0;
        rst_n = 1'b1;
        run(20, si, sr);
        check("t6 no strobe after reset", {30'd0, si, sr}, 32'd0);
        check("t6 abort after reset", {24'd0, abort_cnt}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ppg_channel_demux.md
Name: ppg_channel_demux

Overview:
- Consumes the raw ADC stream together with the LED phase, DC compensation and PGA gain that the front-end controller drives.
- Separates the interleaved IR/RED samples into two channel streams.
- Blanks the analog settling interval after every LED or setting change.
- Box-car averages each channel and tags every average with the DC/gain settings it was taken under.
- Sits between the front-end controller/ADC and the downstream SpO2/heart-rate processing.

Parameters:
- ADC_W, 8, ADC sample width
- DC_W, 7, DC compensation code width
- GAIN_W, 4, PGA gain code width
- BLANK_CYCLES, 4, samples discarded after a phase or setting change (must be >= 1)
- AVG_LOG2, 3, log2 of samples per average (2^AVG_LOG2 = 8)

Ports:
- clk  in  1  system clock; one ADC sample per cycle
- rst_n  in  1  asynchronous, active-low reset
- adc  in  ADC_W  ADC sample
- led_ir  in  1  IR LED on
- led_red  in  1  RED LED on
- dc_comp  in  DC_W  DC compensation code currently applied
- pga_gain  in  GAIN_W  PGA gain code currently applied
- calib_busy  in  1  controller is searching settings; suppress output
- ir_data  out  ADC_W  IR window mean
- ir_valid  out  1  one-cycle strobe, ir_data/tags valid
- ir_dc_tag  out  DC_W  dc_comp in force for the IR window
- ir_gain_tag  out  GAIN_W  pga_gain in force for the IR window
- ir_sat  out  1  IR window contained adc==0 or adc==all-ones
- red_data, red_valid, red_dc_tag, red_gain_tag, red_sat  out  same widths  RED equivalents
- phase_err  out  1  one-cycle strobe on entering led_ir=led_red=1
- abort_cnt  out  8  windows discarded mid-accumulation; saturates at 255

Behaviour:
- Reset: all outputs 0; state IDLE; sum, counters and latched phase/dc/gain cleared. Reset mid-window discards the window; no strobe follows.
- Phase decode: {led_ir,led_red} = 10 is IR, 01 is RED; 00 and 11 are invalid.
- FSM states: IDLE, BLANK, ACC.
- IDLE, on an edge with valid phase and calib_busy=0:
  - Latch phase, dc_comp and pga_gain.
  - blank_cnt <= 0; go to BLANK.
  - The sample on this edge is discarded.
- BLANK:
  - Discard adc; blank_cnt increments each edge.
  - On the edge where blank_cnt == BLANK_CYCLES-1, go to ACC with sum=0 and n=0.
- ACC:
  - Each edge: sum += adc; n += 1; sat flag |= (adc==0 || adc==2^ADC_W-1).
  - On the edge where n == 2^AVG_LOG2-1:
    - Latched-phase channel gets data <= (sum+adc) >> AVG_LOG2 (truncating), tags <= latched dc/gain, sat <= flag including the current sample, valid <= 1.
    - sum, n and flag clear; stay in ACC, so windows are back-to-back.
  - valid is high exactly the one cycle after the last sample edge; otherwise 0.
- Sum register width is ADC_W+AVG_LOG2, so there is no overflow.
- Restart rule, BLANK or ACC: on an edge where the valid phase, dc_comp or pga_gain differs from the latched values, and calib_busy=0:
  - Relatch, blank_cnt <= 0, stay in or return to BLANK.
  - Discard the partial sum.
  - If this happens in ACC with n > 0, abort_cnt increments.
- Invalid phase or calib_busy=1 in any state:
  - Go to IDLE and discard the partial window.
  - abort_cnt increments if in ACC with n > 0.
  - 11 produces a phase_err strobe only on the first edge of a run of 11.
- Priority when events coincide on one edge: reset > calib_busy/invalid phase > setting/phase change > window completion. A change on the would-be last sample edge aborts the window; no strobe.
- ir_* and red_* registers hold their last values between strobes. Both valid strobes are never high in the same cycle.
- Latency from IDLE to first strobe: the detecting edge, plus BLANK_CYCLES edges, plus 2^AVG_LOG2 edges. With defaults, the first change is seen at E0, samples E5..E12 are summed, and the strobe is high during the cycle after E12.

Decomposition:
- Package ppg_pkg:
  - Phase encoding constants PH_NONE=00, PH_RED=01, PH_IR=10, PH_BOTH=11.
  - FSM state localparams IDLE, BLANK, ACC.
  - Shared default widths ADC_W, DC_W, GAIN_W.
- One natural sub-module: ppg_window_acc, holding sum, n, the sat flag, a clear input and a done strobe. It is instantiated once and shared, because only one phase is active at a time. The top level keeps the FSM, change detection, channel steering and abort counter.

Test Plan:
- IR steady, dc=64, gain=7, adc=100 constant, defaults -> first ir_valid in the cycle after E12, ir_data=100, tags 64/7, ir_sat=0; then a strobe every 8 cycles; red_valid stays 0.
- IR steady, adc ramp 10,20,...,80 over the 8 accumulated edges -> ir_data=45 (360>>3 truncated).
- Switch IR to RED mid-window at n=5 -> abort_cnt=1, no ir_valid; first red_valid 13 cycles after the switch edge; RED data correct.
- dc_comp changes 64 to 65 during ACC -> window aborted, re-blanks 4 samples, next strobe tagged 65.
- adc=255 on one sample in a RED window -> red_sat=1 for that window only; next window red_sat=0.
- led_ir=led_red=1 for 3 cycles, then calib_busy=1, then rst_n pulsed mid-window -> one phase_err strobe; IDLE with no strobes; all outputs 0 after reset.
